chess_move_gen: RTL

Parametrised, sequential legal-move generator for one selected square. It reads an external board store one square per cycle and walks rays for sliding pieces, fixed offsets for knight and king, and forward/capture probes for pawns, including the double step. It produces an `N×N` available-move mask, a move count and an illegal-selection flag. It sits between the board-state store and the top-level cursor/display logic, and replaces the single-cycle combinational mask generation.

---
 rtl/chess_move_gen.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/chess_move_gen.sv
// Sequential legal-move generator for one selected square: reads the board one
// square per cycle, walks rays/offsets per piece and reports a destination mask.
module chess_move_gen #(
  parameter int unsigned BOARD_N = 8,
  parameter int unsigned COORD_W = 3,
  parameter int unsigned COUNT_W = 7
) (
  input  logic                         CLOCK,
  input  logic                         RESETN,
  input  logic                         start,
  input  logic                         player,
  input  logic [COORD_W-1:0]           sel_x,
  input  logic [COORD_W-1:0]           sel_y,
  output logic [COORD_W-1:0]           rd_x,
  output logic [COORD_W-1:0]           rd_y,
  input  logic [3:0]                   rd_piece,
  output logic                         busy,
  output logic                         done,
  output logic                         illegal_sel,
  output logic [BOARD_N*BOARD_N-1:0]   avail_moves_out,
  output logic [COUNT_W-1:0]           move_count
);

  localparam int unsigned SW    = COORD_W + 1;
  localparam int unsigned NSQ   = BOARD_N * BOARD_N;
  localparam int unsigned IDX_W = $clog2(NSQ);

  localparam logic [2:0] PC_EMPTY  = 3'd0;
  localparam logic [2:0] PC_PAWN   = 3'd1;
  localparam logic [2:0] PC_BISHOP = 3'd2;
  localparam logic [2:0] PC_KNIGHT = 3'd3;
  localparam logic [2:0] PC_ROOK   = 3'd4;
  localparam logic [2:0] PC_QUEEN  = 3'd5;
  localparam logic [2:0] PC_BAD    = 3'd7;

  localparam logic [SW-1:0] Z  = '0;
  localparam logic [SW-1:0] P1 = SW'(1);
  localparam logic [SW-1:0] P2 = SW'(2);
  localparam logic [SW-1:0] M1 = {SW{1'b1}};
  localparam logic [SW-1:0] M2 = SW'(-2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_PROBE = 2'd2, S_DONE = 2'd3} state_t;

  // Two's-complement {row, col} step for probe number idx of a given piece.
  function automatic logic [2*SW-1:0] probe_off(input logic [2:0] pc, input logic [2:0] idx,
                                                input logic side);
    logic [2:0]    dir;
    logic [SW-1:0] dx, dy, fw;
    fw = side ? P1 : M1;
    case (pc)
      PC_ROOK:   dir = {idx[1:0], 1'b0};
      PC_BISHOP: dir = {idx[1:0], 1'b1};
      default:   dir = idx;
    endcase
    case (dir)
      3'd0:    begin dx = M1; dy = Z;  end
      3'd1:    begin dx = M1; dy = P1; end
      3'd2:    begin dx = Z;  dy = P1; end
      3'd3:    begin dx = P1; dy = P1; end
      3'd4:    begin dx = P1; dy = Z;  end
      3'd5:    begin dx = P1; dy = M1; end
      3'd6:    begin dx = Z;  dy = M1; end
      default: begin dx = M1; dy = M1; end
    endcase
    if (pc == PC_KNIGHT) begin
      case (idx)
        3'd0:    begin dx = M2; dy = M1; end
        3'd1:    begin dx = M2; dy = P1; end
        3'd2:    begin dx = M1; dy = M2; end
        3'd3:    begin dx = M1; dy = P2; end
        3'd4:    begin dx = P1; dy = M2; end
        3'd5:    begin dx = P1; dy = P2; end
        3'd6:    begin dx = P2; dy = M1; end
        default: begin dx = P2; dy = P1; end
      endcase
    end
    if (pc == PC_PAWN) begin
      case (idx[1:0])
        2'd0:    begin dx = fw;      dy = Z;  end
        2'd1:    begin dx = fw + fw; dy = Z;  end
        2'd2:    begin dx = fw;      dy = M1; end
        default: begin dx = fw;      dy = P1; end
      endcase
    end
    return {dx, dy};
  endfunction

  state_t             r_state, w_state_nx;
  logic               r_player;
  logic [COORD_W-1:0] r_sel_x, r_sel_y;
  logic [SW-1:0]      r_tx, r_ty, w_tx_nx, w_ty_nx;
  logic [2:0]         r_piece, w_piece_nx, r_idx, w_idx_nx, w_idx_inc;
  logic               r_f1_empty, w_f1_nx, r_illegal, w_illegal_nx;
  logic [NSQ-1:0]     r_acc, w_acc_nx;
  logic               r_busy, r_done, r_ill_out;
  logic [NSQ-1:0]     r_avail;
  logic [COUNT_W-1:0] r_count, w_pop;
  logic               w_onboard, w_empty, w_own, w_opp, w_slider, w_last, w_start_row, w_mark;
  logic [SW-1:0]      w_cur_dx, w_cur_dy, w_nxt_dx, w_nxt_dy, w_fst_dx, w_fst_dy;
  logic [IDX_W-1:0]   w_bit;

  assign w_idx_inc   = r_idx + 3'd1;
  // Negative coordinates read as large unsigned values, so one compare covers both edges.
  assign w_onboard   = (r_tx < SW'(BOARD_N)) && (r_ty < SW'(BOARD_N));
  assign w_empty     = (rd_piece[2:0] == PC_EMPTY);
  assign w_own       = !w_empty && (rd_piece[3] == r_player);
  assign w_opp       = !w_empty && (rd_piece[3] != r_player);
  assign w_slider    = (r_piece == PC_ROOK) || (r_piece == PC_BISHOP) || (r_piece == PC_QUEEN);
  assign w_last      = ((r_piece == PC_ROOK) || (r_piece == PC_BISHOP) || (r_piece == PC_PAWN))
                       ? (r_idx == 3'd3) : (r_idx == 3'd7);
  assign w_start_row = (r_sel_x == (r_player ? COORD_W'(1) : COORD_W'(BOARD_N - 2)));
  assign w_bit       = IDX_W'(r_tx[COORD_W-1:0]) * IDX_W'(BOARD_N) + IDX_W'(r_ty[COORD_W-1:0]);

  assign {w_cur_dx, w_cur_dy} = probe_off(r_piece, r_idx, r_player);
  assign {w_nxt_dx, w_nxt_dy} = probe_off(r_piece, w_idx_inc, r_player);
  assign {w_fst_dx, w_fst_dy} = probe_off(rd_piece[2:0], 3'd0, r_player);

  // Next-state, probe sequencing and mask accumulation.
  always_comb begin
    w_state_nx   = r_state;
    w_tx_nx      = r_tx;
    w_ty_nx      = r_ty;
    w_piece_nx   = r_piece;
    w_idx_nx     = r_idx;
    w_f1_nx      = r_f1_empty;
    w_illegal_nx = r_illegal;
    w_acc_nx     = r_acc;
    w_mark       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx   = S_FETCH;
          w_tx_nx      = SW'(sel_x);
          w_ty_nx      = SW'(sel_y);
          w_acc_nx     = '0;
          w_illegal_nx = 1'b0;
        end
      end
      S_FETCH: begin
        if (!w_onboard || w_empty || (rd_piece[3] != r_player) || (rd_piece[2:0] == PC_BAD)) begin
          w_illegal_nx = 1'b1;
          w_state_nx   = S_DONE;
        end else begin
          w_piece_nx = rd_piece[2:0];
          w_idx_nx   = 3'd0;
          w_f1_nx    = 1'b0;
          w_tx_nx    = r_tx + w_fst_dx;
          w_ty_nx    = r_ty + w_fst_dy;
          w_state_nx = S_PROBE;
        end
      end
      S_PROBE: begin
        if (r_piece == PC_PAWN) begin
          case (r_idx[1:0])
            2'd0:    w_mark = w_onboard && w_empty;
            2'd1:    w_mark = w_start_row && r_f1_empty && w_onboard && w_empty;
            default: w_mark = w_onboard && w_opp;
          endcase
          if (r_idx == 3'd0) w_f1_nx = w_onboard && w_empty;
        end else begin
          w_mark = w_onboard && !w_own;
        end
        if (w_mark) w_acc_nx[w_bit] = 1'b1;
        if (w_slider && w_onboard && w_empty) begin
          w_tx_nx = r_tx + w_cur_dx;
          w_ty_nx = r_ty + w_cur_dy;
        end else if (w_last) begin
          w_state_nx = S_DONE;
        end else begin
          w_idx_nx = w_idx_inc;
          w_tx_nx  = SW'(r_sel_x) + w_nxt_dx;
          w_ty_nx  = SW'(r_sel_y) + w_nxt_dy;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NSQ; i++) w_pop = w_pop + COUNT_W'(w_acc_nx[i]);
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= S_IDLE;
      r_player   <= 1'b0;
      r_sel_x    <= '0;
      r_sel_y    <= '0;
      r_tx       <= '0;
      r_ty       <= '0;
      r_piece    <= '0;
      r_idx      <= '0;
      r_f1_empty <= 1'b0;
      r_illegal  <= 1'b0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ill_out  <= 1'b0;
      r_avail    <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_tx       <= w_tx_nx;
      r_ty       <= w_ty_nx;
      r_piece    <= w_piece_nx;
      r_idx      <= w_idx_nx;
      r_f1_empty <= w_f1_nx;
      r_illegal  <= w_illegal_nx;
      r_acc      <= w_acc_nx;
      if ((r_state == S_IDLE) && start) begin
        r_player <= player;
        r_sel_x  <= sel_x;
        r_sel_y  <= sel_y;
      end
      r_busy <= (w_state_nx == S_FETCH) || (w_state_nx == S_PROBE);
      r_done <= (w_state_nx == S_DONE);
      // Results land on DONE entry so they are valid alongside done.
      if (w_state_nx == S_DONE) begin
        r_avail   <= w_acc_nx;
        r_count   <= w_pop;
        r_ill_out <= w_illegal_nx;
      end
    end
  end

  assign rd_x            = r_tx[COORD_W-1:0];
  assign rd_y            = r_ty[COORD_W-1:0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign illegal_sel     = r_ill_out;
  assign avail_moves_out = r_avail;
  assign move_count      = r_count;

endmodule
